// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer: raises INT, walks the two-pulse INTA cycle,
// drives the vector byte and issues one-hot ISR set/clear pulses to the priority stage.
module interrupt_ack_sequencer #(
  parameter logic AEOI_DEFAULT = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  input  logic [2:0] req_level,
  input  logic       INTA_n,
  input  logic       icw2_we,
  input  logic [4:0] icw2_data,
  input  logic       aeoi_we,
  input  logic       aeoi_data,
  input  logic       eoi_cmd,
  output logic       INT,
  output logic [7:0] isr_set,
  output logic [7:0] isr_clr,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    ACK1     = 3'd2,
    ACK2     = 3'd3,
    WAIT_EOI = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       inta_q;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] lvl;
  logic [2:0] lvl_next;
  logic [4:0] base;
  logic       aeoi;
  logic [7:0] isr_set_next;
  logic [7:0] isr_clr_next;
  logic [7:0] vec_data_next;

  assign inta_fall = inta_q & ~INTA_n;
  assign inta_rise = ~inta_q & INTA_n;

  assign INT       = (state == REQ);
  assign vec_valid = (state == ACK2);
  assign busy      = (state != IDLE);

  // History resets to 1 so a low INTA_n right after reset reads as a fall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      inta_q   <= 1'b1;
      lvl      <= 3'd0;
      base     <= 5'd0;
      aeoi     <= AEOI_DEFAULT;
      isr_set  <= 8'h00;
      isr_clr  <= 8'h00;
      vec_data <= 8'h00;
    end else begin
      state    <= state_next;
      inta_q   <= INTA_n;
      lvl      <= lvl_next;
      isr_set  <= isr_set_next;
      isr_clr  <= isr_clr_next;
      vec_data <= vec_data_next;
      if (icw2_we) base <= icw2_data;
      if (aeoi_we) aeoi <= aeoi_data;
    end
  end

  // The vector and AEOI decision read the registered base/aeoi, so a
  // coincident write only takes effect for the next interrupt.
  always_comb begin
    state_next    = state;
    lvl_next      = lvl;
    isr_set_next  = 8'h00;
    isr_clr_next  = 8'h00;
    vec_data_next = vec_data;
    case (state)
      IDLE: begin
        if (req_valid) state_next = REQ;
      end
      REQ: begin
        if (inta_fall) begin
          lvl_next     = req_valid ? req_level : 3'd7;
          isr_set_next = 8'd1 << lvl_next;
          state_next   = ACK1;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          vec_data_next = {base, lvl};
          state_next    = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          if (aeoi) begin
            isr_clr_next = 8'd1 << lvl;
            state_next   = IDLE;
          end else begin
            state_next = WAIT_EOI;
          end
        end
      end
      WAIT_EOI: begin
        if (eoi_cmd) begin
          isr_clr_next = 8'd1 << lvl;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
